// File: rtl/multi_mode_ff_reg_if.sv
// Bus bundle for multi_mode_ff_reg: mode control, per-bit operands and registered state.
// With MULTI_MODE_FF_SR_ERR_EN defined the bundle also carries the sticky err flag.
interface multi_mode_ff_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]       mode_in;
  logic             mode_ld;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [1:0]       mode;
  logic [WIDTH-1:0] chg;
`ifdef MULTI_MODE_FF_SR_ERR_EN
  logic             err;
`endif

  modport master (
    output mode_in, mode_ld, en, a, b,
`ifdef MULTI_MODE_FF_SR_ERR_EN
    input  err,
`endif
    input  q, qn, mode, chg
  );

  modport slave (
    input  mode_in, mode_ld, en, a, b,
`ifdef MULTI_MODE_FF_SR_ERR_EN
    output err,
`endif
    output q, qn, mode, chg
  );
endinterface

// File: rtl/multi_mode_ff_reg.sv
// WIDTH-bit register bank whose bits behave as D, T, JK or SR flip-flops under a shared mode register.
// Define MULTI_MODE_FF_SR_ERR_EN to add a sticky err flag raised by illegal SR (S=R=1) pairs.
module multi_mode_ff_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  multi_mode_ff_reg_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e            mode_q;
  mode_e            mode_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] chg_q;
  logic [WIDTH-1:0] chg_d;
`ifdef MULTI_MODE_FF_SR_ERR_EN
  logic             err_q;
  logic             err_d;
`endif

  function automatic logic [WIDTH-1:0] next_t(input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] t);
    return cur ^ t;
  endfunction

  // J=K=1 toggles, J alone sets, K alone clears.
  function automatic logic [WIDTH-1:0] next_jk(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] j,
                                               input logic [WIDTH-1:0] k);
    return (j & ~cur) | (~k & cur);
  endfunction

  // S=R=1 is illegal and holds, so only an exclusive S or R moves the bit.
  function automatic logic [WIDTH-1:0] next_sr(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] r);
    return (s & ~r) | (cur & ~r) | (cur & s);
  endfunction

  // Next-state selection; q always evaluates under the mode held before this edge.
  always_comb begin
    mode_d = mode_q;
    q_d    = q_q;
    chg_d  = {WIDTH{1'b0}};

    if (bus.mode_ld) begin
      mode_d = mode_e'(bus.mode_in);
    end else begin
      mode_d = mode_q;
    end

    if (bus.en) begin
      case (mode_q)
        MODE_D:  q_d = bus.a;
        MODE_T:  q_d = next_t(q_q, bus.a);
        MODE_JK: q_d = next_jk(q_q, bus.a, bus.b);
        MODE_SR: q_d = next_sr(q_q, bus.a, bus.b);
        default: q_d = q_q;
      endcase
    end else begin
      q_d = q_q;
    end

    chg_d = q_q ^ q_d;
  end

`ifdef MULTI_MODE_FF_SR_ERR_EN
  // Sticky flag: once any bit sees S=R=1 on an enabled SR edge it stays set until reset.
  always_comb begin
    err_d = err_q;
    if (bus.en && (mode_q == MODE_SR) && (|(bus.a & bus.b))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end
`endif

  // State registers; reset also discards any mode load arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= RST_VAL;
      chg_q  <= {WIDTH{1'b0}};
      mode_q <= MODE_D;
`ifdef MULTI_MODE_FF_SR_ERR_EN
      err_q  <= 1'b0;
`endif
    end else begin
      q_q    <= q_d;
      chg_q  <= chg_d;
      mode_q <= mode_d;
`ifdef MULTI_MODE_FF_SR_ERR_EN
      err_q  <= err_d;
`endif
    end
  end

  assign bus.q    = q_q;
  assign bus.qn   = ~q_q;
  assign bus.chg  = chg_q;
  assign bus.mode = mode_q;
`ifdef MULTI_MODE_FF_SR_ERR_EN
  assign bus.err  = err_q;
`endif

endmodule

// File: tb/tb_multi_mode_ff_reg.sv
// Scoreboard bench for multi_mode_ff_reg (WIDTH=8, RST_VAL=8'hA5).
module tb_multi_mode_ff_reg;

  localparam logic [7:0] RV = 8'hA5;

  typedef struct {
    logic [7:0] q;
    logic [7:0] chg;
    logic [1:0] mode;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;

  logic [7:0] m_q;
  logic [1:0] m_mode;
  logic       m_err;

  multi_mode_ff_reg_if #(.WIDTH(8)) bus ();

  multi_mode_ff_reg #(.WIDTH(8), .RST_VAL(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_next(input logic [1:0] md, input logic [7:0] cur,
                                            input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case (md)
        2'b00: r[i] = av[i];
        2'b01: r[i] = av[i] ? ~cur[i] : cur[i];
        2'b10: case ({av[i], bv[i]})
                 2'b00: r[i] = cur[i];
                 2'b01: r[i] = 1'b0;
                 2'b10: r[i] = 1'b1;
                 default: r[i] = ~cur[i];
               endcase
        default: case ({av[i], bv[i]})
                   2'b01: r[i] = 1'b0;
                   2'b10: r[i] = 1'b1;
                   default: r[i] = cur[i];
                 endcase
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    m_q    = RV;
    m_mode = 2'b00;
    m_err  = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle at the falling edge, push the expectation, sample 1 ns after the rising edge.
  task automatic apply(input logic [1:0] mi, input logic ld, input logic en,
                       input logic [7:0] av, input logic [7:0] bv);
    exp_t x;
    logic [7:0] nq;
    @(negedge clk);
    rst         = 1'b0;
    bus.mode_in = mi;
    bus.mode_ld = ld;
    bus.en      = en;
    bus.a       = av;
    bus.b       = bv;
    nq = en ? model_next(m_mode, m_q, av, bv) : m_q;
    if (en && m_mode == 2'b11 && (|(av & bv))) m_err = 1'b1;
    x.q    = nq;
    x.chg  = m_q ^ nq;
    x.mode = ld ? mi : m_mode;
    x.err  = m_err;
    m_q    = nq;
    m_mode = x.mode;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mode_in = 2'b10; bus.mode_ld = 1'b1; bus.en = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    model_reset();
    #2;
    checks++;
    if ({bus.q, bus.qn, bus.chg, bus.mode} !== {8'hA5, 8'h5A, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset: got q=%h qn=%h chg=%h mode=%0d, expected q=a5 qn=5a chg=00 mode=0",
               bus.q, bus.qn, bus.chg, bus.mode);
    end
`ifdef MULTI_MODE_FF_SR_ERR_EN
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got err=%b, expected 0", bus.err);
    end
`endif
  endtask

  task automatic test_d();
    apply(2'b00, 1'b0, 1'b1, 8'h3C, 8'h00);
    e = sb.pop_front();
    checks++;
    if ({bus.q, bus.chg} !== {8'h3C, 8'h99} || {bus.q, bus.qn, bus.chg, bus.mode} !== {e.q, ~e.q, e.chg, e.mode}) begin
      errors++;
      $display("FAIL d_first: got q=%h qn=%h chg=%h mode=%0d, expected q=3c chg=99 mode=%0d",
               bus.q, bus.qn, bus.chg, bus.mode, e.mode);
    end
  endtask

  task automatic test_t();
    apply(2'b01, 1'b1, 1'b1, 8'h00, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) apply(2'b01, 1'b0, 1'b1, 8'hFF, 8'h00);
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.qn, bus.chg, bus.mode} !== {e.q, ~e.q, e.chg, e.mode} || (i > 0 && bus.chg !== 8'hFF)) begin
        errors++;
        $display("FAIL t_step%0d: got q=%h qn=%h chg=%h mode=%0d, expected q=%h chg=%h mode=%0d",
                 i, bus.q, bus.qn, bus.chg, bus.mode, e.q, e.chg, e.mode);
      end
    end
  endtask

  task automatic test_jk();
    logic [7:0] jv[4] = '{8'h00, 8'hF0, 8'hFF, 8'h00};
    logic [7:0] kv[4] = '{8'h00, 8'h0F, 8'hFF, 8'h00};
    logic [7:0] qv[4] = '{8'h00, 8'hF0, 8'h0F, 8'h0F};
    for (int i = 0; i < 4; i++) begin
      apply(2'b10, (i == 0), 1'b1, jv[i], kv[i]);
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.qn, bus.chg, bus.mode} !== {e.q, ~e.q, e.chg, e.mode} || bus.q !== qv[i]) begin
        errors++;
        $display("FAIL jk_step%0d: got q=%h qn=%h chg=%h mode=%0d, expected q=%h chg=%h mode=%0d",
                 i, bus.q, bus.qn, bus.chg, bus.mode, qv[i], e.chg, e.mode);
      end
    end
  endtask

  task automatic test_sr();
    logic [7:0] sv[4] = '{8'h00, 8'h81, 8'h00, 8'h02};
    logic [7:0] rv[4] = '{8'hFF, 8'h01, 8'h80, 8'h00};
    logic [7:0] qv[4] = '{8'h00, 8'h80, 8'h00, 8'h02};
    for (int i = 0; i < 4; i++) begin
      apply(2'b11, (i == 0), 1'b1, sv[i], rv[i]);
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.qn, bus.chg, bus.mode} !== {e.q, ~e.q, e.chg, e.mode} || bus.q !== qv[i]) begin
        errors++;
        $display("FAIL sr_step%0d: got q=%h qn=%h chg=%h mode=%0d, expected q=%h chg=%h mode=%0d",
                 i, bus.q, bus.qn, bus.chg, bus.mode, qv[i], e.chg, e.mode);
      end
`ifdef MULTI_MODE_FF_SR_ERR_EN
      checks++;
      if (bus.err !== e.err || bus.err !== (i >= 1)) begin
        errors++;
        $display("FAIL sr_err%0d: got err=%b, expected %b", i, bus.err, e.err);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    apply(2'b01, 1'b1, 1'b1, 8'h00, 8'h00);
    e = sb.pop_front();
    apply(2'b01, 1'b0, 1'b1, 8'hFF, 8'h00);
    e = sb.pop_front();
    checks++;
    if ({bus.q, bus.mode} !== {e.q, e.mode}) begin
      errors++;
      $display("FAIL pre_async: got q=%h mode=%0d, expected q=%h mode=%0d", bus.q, bus.mode, e.q, e.mode);
    end
    #2;
    bus.mode_ld = 1'b1;
    bus.mode_in = 2'b10;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({bus.q, bus.qn, bus.chg, bus.mode} !== {8'hA5, 8'h5A, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL async_rst: got q=%h qn=%h chg=%h mode=%0d, expected q=a5 qn=5a chg=00 mode=0",
               bus.q, bus.qn, bus.chg, bus.mode);
    end
    apply(2'b00, 1'b0, 1'b1, 8'h5A, 8'h00);
    e = sb.pop_front();
    checks++;
    if ({bus.q, bus.chg, bus.mode} !== {8'h5A, 8'hFF, 2'b00} || bus.q !== e.q) begin
      errors++;
      $display("FAIL post_rst_d: got q=%h chg=%h mode=%0d, expected q=5a chg=ff mode=0",
               bus.q, bus.chg, bus.mode);
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 4; i++) begin
      apply(2'(i + 1), 1'b1, 1'b0, 8'($urandom), 8'($urandom));
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.qn, bus.chg, bus.mode} !== {e.q, ~e.q, e.chg, e.mode} || bus.chg !== 8'h00 || bus.q !== 8'h5A) begin
        errors++;
        $display("FAIL en_off%0d: got q=%h chg=%h mode=%0d, expected q=5a chg=00 mode=%0d",
                 i, bus.q, bus.chg, bus.mode, e.mode);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      apply(2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
      e = sb.pop_front();
      checks++;
      if ({bus.q, bus.qn, bus.chg, bus.mode} !== {e.q, ~e.q, e.chg, e.mode}) begin
        errors++;
        $display("FAIL b2b_%0d: got q=%h qn=%h chg=%h mode=%0d, expected q=%h chg=%h mode=%0d",
                 i, bus.q, bus.qn, bus.chg, bus.mode, e.q, e.chg, e.mode);
      end
`ifdef MULTI_MODE_FF_SR_ERR_EN
      checks++;
      if (bus.err !== e.err) begin
        errors++;
        $display("FAIL b2b_err%0d: got err=%b, expected %b", i, bus.err, e.err);
      end
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_d();
    test_t();
    test_jk();
    test_sr();
    test_async_reset();
    test_enable();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_mode_ff_reg.md
MULTI_MODE_FF_REG -- requirements
Module: multi_mode_ff_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of flip-flop bits (legal range 1..32).
REQ-002 The block SHALL have parameter RST_VAL, default 0, a WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port mode_in, input, 2 bits: requested mode (00 D, 01 T, 10 JK, 11 SR).
REQ-007 Port mode_ld, input, 1 bit: mode_in is captured into the mode register when high.
REQ-008 Port en, input, 1 bit: bit-update enable.
REQ-009 Port a, input, WIDTH bits: D / T / J / S per bit, depending on mode.
REQ-010 Port b, input, WIDTH bits: K (JK mode) or R (SR mode); ignored in D and T modes.
REQ-011 Port q, output, WIDTH bits: registered state.
REQ-012 Port qn, output, WIDTH bits: always the bitwise inverse of q.
REQ-013 Port mode, output, 2 bits: currently active mode register.
REQ-014 Port chg, output, WIDTH bits: registered mask of q bits that changed at the last clock edge.
REQ-015 Port err, output, 1 bit: sticky illegal-input flag (present only with the macro; see Configuration).

Function
REQ-016 On a rising edge with en=1, each bit i SHALL take its next value from the active mode:
- D: q[i] <= a[i].
- T: toggle if a[i]=1, else hold.
- JK: 00 hold, 01 reset (K=1), 10 set (J=1), 11 toggle.
- SR: 00 hold, 01 clear (R=1), 10 set (S=1), 11 illegal, bit holds.
REQ-017 With en=0, q SHALL hold and chg SHALL become all-zero at that edge.
REQ-018 With mode_ld=1, mode SHALL take mode_in at the edge. The update to q at that same edge SHALL use the previous mode, so the new mode first affects q one cycle later.
REQ-019 Latency: q and chg SHALL update at the same edge that samples the inputs. qn SHALL be combinational from q, with zero added latency.
REQ-020 chg SHALL equal q_old XOR q_new for each edge.
REQ-021 Bits SHALL be fully independent; per-bit illegal SR pairs SHALL NOT affect other bits.
REQ-022 With WIDTH=1, behaviour SHALL be identical per bit, with no special casing.

Reset
REQ-023 While rst=1, independent of clk, the outputs SHALL be forced to: q=RST_VAL, qn=~RST_VAL, mode=00 (D), chg=0, err=0.
REQ-024 Deassertion of rst SHALL take effect on the next rising clk edge. Inputs present at that edge SHALL be applied normally.
REQ-025 Reset asserted mid-operation, including during a mode_ld cycle, SHALL discard any pending mode change.

Configuration
REQ-026 Macro MULTI_MODE_FF_SR_ERR_EN SHALL control the err port.
REQ-027 With the macro defined, err SHALL set at any enabled edge in SR mode where any bit has a[i]=b[i]=1.
REQ-028 With the macro defined, err SHALL remain 1 until rst, and the affected bits SHALL still hold.
REQ-029 With the macro undefined, the err port and its logic SHALL be absent. An illegal SR pair SHALL hold silently.

Verification
REQ-030 Reset/D scenario (WIDTH=8, RST_VAL=8'hA5): rst pulse -> q=A5, qn=5A, mode=00, chg=00. Then rst=0, en=1, a=3C -> next edge q=3C, chg=99.
REQ-031 T scenario: mode_ld=1, mode_in=01 for one edge (q follows D at that edge). Then a=FF, en=1 for 4 edges -> q alternates ~q/q each edge, chg=FF every edge.
REQ-032 JK scenario: mode JK, q=00, J=F0, K=0F -> q=F0. Then J=K=FF -> q=0F. Then J=K=00 -> q holds 0F, chg=00.
REQ-033 SR/err scenario (macro on): mode SR, q=00, S=81, R=01 -> q=80, err=1. Bit 0 holds, bit 7 sets, and err stays 1 across later legal cycles until rst.
REQ-034 Async reset scenario: assert rst 3 ns after an edge in T mode -> q=RST_VAL immediately, mode=00 without waiting for clk. Then release rst -> the first edge operates in D mode.
REQ-035 Enable scenario: en=0 with mode_ld=1 and varying a -> q holds, chg=00, mode still updates.
